pe_tile_seq: RTL

Command-driven sequencer for the `pe_stg_2` systolic PE array.
- Accepts one tile command at a time.
- Drives the array-wide control lines `mode_sel`, `psu_clr`, `sys_buf_en` and `y_sel` through clear → compute → flush → drain phases.
- Paces the left-edge activation feeder and flags valid drained result rows.
- Sits between the tile-level instruction decoder and the PE array plus its activation and result buffers.

---
 rtl/pe_tile_seq.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/pe_tile_seq.sv
`timescale 1ns/1ps
// Purpose: command sequencer for the pe_stg_2 systolic array (clear, compute, flush, drain, fin).
// Latency: 1 + clr + k + FLUSH_CYC + ROWS + 1 cycles accept-to-done for matmul with no bubbles.
// Backpressure: one command at a time (cmd_ready only in IDLE); feeder bubbles stall the beat count; drain has none.
module pe_tile_seq #(
    parameter int ROWS      = 16,
    parameter int FLUSH_CYC = 18,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [CNT_W-1:0] cmd_k,
    input  logic             cmd_clr,
    input  logic             cmd_y_sel,
    input  logic             act_avail,
    output logic             act_rd_en,
    output logic [1:0]       mode_sel_out,
    output logic             psu_clr_out,
    output logic             sys_buf_en_out,
    output logic             y_sel_out,
    output logic             out_valid,
    output logic             out_last,
    output logic             done,
    output logic             busy
);

    // Phase counter must hold the longer of the flush and drain lengths.
    localparam int PH_MAX = (ROWS > FLUSH_CYC) ? ROWS : FLUSH_CYC;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    localparam logic [PH_W-1:0]  FLUSH_LAST = PH_W'(FLUSH_CYC - 1);
    localparam logic [PH_W-1:0]  DRAIN_LAST = PH_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] K_ONE      = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_COMPUTE,
        S_FLUSH,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [1:0]        r_mode;
    logic [CNT_W-1:0]  r_k;
    logic              r_y_sel;
    logic [CNT_W-1:0]  r_beat;
    logic [PH_W-1:0]   r_ph;
    logic              r_psu_clr;
    logic              r_sys_buf_en;
    logic              r_out_valid;
    logic              r_out_last;

    logic [1:0]        w_cmd_mode;
    logic              w_accept;
    logic              w_pop;
    logic              w_last_beat;

    // Mode 01 is an alias of matmul; fold it at the input so the rest only sees 00/10/11.
    assign w_cmd_mode  = (cmd_mode == 2'b01) ? 2'b00 : cmd_mode;
    assign w_accept    = (r_state == S_IDLE) && cmd_valid;
    assign w_pop       = (r_state == S_COMPUTE) && act_avail;
    // r_k is nonzero whenever COMPUTE is entered, so k-1 never underflows here.
    assign w_last_beat = w_pop && (r_beat == (r_k - K_ONE));

    assign mode_sel_out   = r_mode;
    assign y_sel_out      = r_y_sel;
    assign psu_clr_out    = r_psu_clr;
    assign sys_buf_en_out = r_sys_buf_en;
    assign out_valid      = r_out_valid;
    assign out_last       = r_out_last;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus the handshake/feeder outputs that follow the current state.
    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        act_rd_en   = 1'b0;
        done        = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    // clr only steers this decision, so it is not kept after acceptance.
                    if ((w_cmd_mode == 2'b00) && cmd_clr) begin
                        w_state_nxt = S_CLEAR;
                    end else if (cmd_k != '0) begin
                        w_state_nxt = S_COMPUTE;
                    end else begin
                        w_state_nxt = S_FLUSH;
                    end
                end
            end
            S_CLEAR: begin
                w_state_nxt = (r_k != '0) ? S_COMPUTE : S_FLUSH;
            end
            S_COMPUTE: begin
                act_rd_en = act_avail;
                if (w_last_beat) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (r_ph == FLUSH_LAST) begin
                    w_state_nxt = (r_mode == 2'b00) ? S_DRAIN : S_FIN;
                end
            end
            S_DRAIN: begin
                if (r_ph == DRAIN_LAST) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Latch the command on acceptance; mode and Y select then hold until the next command.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode  <= 2'b00;
            r_k     <= '0;
            r_y_sel <= 1'b0;
        end else if (w_accept) begin
            r_mode  <= w_cmd_mode;
            r_k     <= cmd_k;
            r_y_sel <= cmd_y_sel;
        end
    end

    // Beat counter advances only on real pops, so bubbles stretch COMPUTE without losing beats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_beat <= '0;
        end else if (w_accept) begin
            r_beat <= '0;
        end else if (w_pop) begin
            r_beat <= r_beat + K_ONE;
        end
    end

    // Phase counter restarts on every state change and times FLUSH and DRAIN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ph <= '0;
        end else if (w_state_nxt != r_state) begin
            r_ph <= '0;
        end else if ((r_state == S_FLUSH) || (r_state == S_DRAIN)) begin
            r_ph <= r_ph + PH_W'(1);
        end
    end

    // Array controls decoded from next state so they come straight off flops aligned with the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_psu_clr    <= 1'b0;
            r_sys_buf_en <= 1'b0;
        end else begin
            r_psu_clr    <= (w_state_nxt == S_CLEAR);
            r_sys_buf_en <= (w_state_nxt == S_DRAIN);
        end
    end

    // Result qualifiers trail the shift enable by one cycle to match the registered bottom row.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_out_valid <= r_sys_buf_en;
            r_out_last  <= (r_state == S_DRAIN) && (r_ph == DRAIN_LAST);
        end
    end

endmodule
